// File: rtl/systolic_pkg.sv
// Shared constants and operand decoding for the weight-stationary systolic array.
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 16;

    // Reduce an 8-bit lane to a 9-bit signed operand. Only the low `width`
    // bits carry data (1, 2, 4 or 8; anything else counts as 8). The value is
    // sign-extended from its top data bit when sgn is set, zero-extended
    // otherwise, so signed 1-bit operands take the values {0, -1}.
    function automatic logic signed [DATA_W:0] decode_operand(
        input logic [DATA_W-1:0] value,
        input logic [3:0]        width,
        input logic              sgn
    );
        logic [DATA_W-1:0] mask;
        logic              msb;
        logic [DATA_W-1:0] field;
        case (width)
            4'd1:    begin mask = 8'h01; msb = value[0]; end
            4'd2:    begin mask = 8'h03; msb = value[1]; end
            4'd4:    begin mask = 8'h0F; msb = value[3]; end
            default: begin mask = 8'hFF; msb = value[7]; end
        endcase
        field = value & mask;
        if (sgn && msb) begin
            return {1'b1, field | ~mask};
        end
        return {1'b0, field};
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: decodes its input and weight lanes, forms a 16-bit
// signed product and adds it to the partial sum arriving from the row above.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    input  logic [3:0]        in_width,
    input  logic [3:0]        weight_width,
    input  logic              s_in,
    input  logic              s_weight,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out
);

    logic signed [DATA_W:0]       x_dec;
    logic signed [DATA_W:0]       w_dec;
    logic signed [2*DATA_W+1:0]   prod_full;
    logic signed [PROD_W-1:0]     prod;
    logic [ACC_W-1:0]             prod_ext;

    assign x_dec     = decode_operand(x, in_width, s_in);
    assign w_dec     = decode_operand(w, weight_width, s_weight);
    assign prod_full = x_dec * w_dec;
    // The product is defined as a 16-bit signed quantity; the top bits of the
    // full 18-bit result are dropped deliberately.
    assign prod      = prod_full[PROD_W-1:0];
    assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Register the running sum; accumulation wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_out <= '0;
        end else begin
            psum_out <= psum_in + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// Weight-stationary ARRAY_SIZE x ARRAY_SIZE MAC array. Input lanes are skewed
// by row index so that partial sums flowing down each column meet the matching
// input element; every column therefore emerges aligned, ARRAY_SIZE edges
// after the vector was sampled.
//
// Handshake: there is none. The array computes every cycle; a consumer reads
// psums ARRAY_SIZE-1 edges after the edge that sampled the input vector.
// Weights, widths and sign flags are combinational and must stay stable while
// a computation is in flight.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [3:0]                             in_width,
    input  logic [3:0]                             weight_width,
    input  logic                                   s_in,
    input  logic                                   s_weight,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] weights,
    input  logic [ARRAY_SIZE*DATA_W-1:0]           inputs,
    output logic [ARRAY_SIZE*ACC_W-1:0]            psums
);

    logic [ARRAY_SIZE-1:0][DATA_W-1:0]                 row_x;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0][ACC_W-1:0]  psum_grid;

    genvar r, c;

    // Input skew: row r sees inputs[r] delayed by r registers.
    generate
        for (r = 0; r < ARRAY_SIZE; r++) begin : g_skew
            if (r == 0) begin : g_direct
                assign row_x[0] = inputs[DATA_W-1:0];
            end else begin : g_chain
                logic [DATA_W-1:0] sk [r];
                // Shift register: stage 0 samples the lane, later stages follow.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < r; i++) begin
                            sk[i] <= '0;
                        end
                    end else begin
                        sk[0] <= inputs[r*DATA_W +: DATA_W];
                        for (int i = 1; i < r; i++) begin
                            sk[i] <= sk[i-1];
                        end
                    end
                end
                assign row_x[r] = sk[r-1];
            end
        end
    endgenerate

    // PE grid: row 0 starts from zero, other rows add onto the row above.
    generate
        for (r = 0; r < ARRAY_SIZE; r++) begin : g_row
            for (c = 0; c < ARRAY_SIZE; c++) begin : g_col
                logic [ACC_W-1:0] psum_in;
                if (r == 0) begin : g_top
                    assign psum_in = '0;
                end else begin : g_inner
                    assign psum_in = psum_grid[r-1][c];
                end
                systolic_pe u_pe (
                    .clk          (clk),
                    .rst_n        (rst_n),
                    .x            (row_x[r]),
                    .w            (weights[(r*ARRAY_SIZE+c)*DATA_W +: DATA_W]),
                    .in_width     (in_width),
                    .weight_width (weight_width),
                    .s_in         (s_in),
                    .s_weight     (s_weight),
                    .psum_in      (psum_in),
                    .psum_out     (psum_grid[r][c])
                );
            end
        end
    endgenerate

    // Output mapping: the bottom row's registered sums are the results.
    generate
        for (c = 0; c < ARRAY_SIZE; c++) begin : g_out
            assign psums[c*ACC_W +: ACC_W] = psum_grid[ARRAY_SIZE-1][c];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array.sv
// Directed and randomized checks of the systolic array against a dot-product
// reference computed from the operand and accumulation rules.
module tb_systolic_array;

    localparam int N = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       in_w;
    logic [3:0]       w_w;
    logic             s_i;
    logic             s_w;
    logic [N*N*8-1:0] wts;
    logic [N*8-1:0]   ins;
    logic [N*32-1:0]  psums;

    int checks = 0;
    int errors = 0;

    // Input vectors in the order the array sampled them since the last reset.
    logic [N*8-1:0] hist[$];

    systolic_array #(.ARRAY_SIZE(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_width     (in_w),
        .weight_width (w_w),
        .s_in         (s_i),
        .s_weight     (s_w),
        .weights      (wts),
        .inputs       (ins),
        .psums        (psums)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_dec(logic [7:0] value, logic [3:0] width, logic sgn);
        int bits;
        int v;
        bits = (width == 4'd1 || width == 4'd2 || width == 4'd4) ? int'(width) : 8;
        v = int'(value) % (1 << bits);
        if (sgn && v >= (1 << (bits - 1))) v = v - (1 << bits);
        return v;
    endfunction

    function automatic logic [31:0] ref_dot(logic [N*8-1:0] vec, int col);
        logic [31:0]        acc;
        int                 p;
        logic signed [15:0] p16;
        acc = 32'd0;
        for (int r = 0; r < N; r++) begin
            p = ref_dec(vec[r*8 +: 8], in_w, s_i) *
                ref_dec(wts[(r*N+col)*8 +: 8], w_w, s_w);
            p16 = p[15:0];
            acc = acc + {{16{p16[15]}}, p16};
        end
        return acc;
    endfunction

    // ---------------- driver tasks ----------------
    // Compare every lane against the model for the vector sampled N-1 edges ago.
    task automatic check_model(string tag);
        logic [31:0] exp;
        for (int c = 0; c < N; c++) begin
            exp = (hist.size() >= N) ? ref_dot(hist[hist.size()-N], c) : 32'd0;
            checks++;
            assert (psums[c*32 +: 32] === exp) else begin
                errors++;
                $error("FAIL %s lane %0d observed %h expected %h", tag, c, psums[c*32 +: 32], exp);
            end
        end
    endtask

    task automatic check_const(string tag, int c, logic [31:0] exp);
        checks++;
        assert (psums[c*32 +: 32] === exp) else begin
            errors++;
            $error("FAIL %s lane %0d observed %h expected %h", tag, c, psums[c*32 +: 32], exp);
        end
    endtask

    // One clock edge with the current inputs, then check after it settles.
    task automatic tick(string tag);
        hist.push_back(ins);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse away from the edge; outputs must clear at once.
    task automatic do_reset(string tag);
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < N; c++) check_const(tag, c, 32'd0);
        hist.delete();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) check_const(tag, c, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(logic [3:0] iw, logic [3:0] ww, logic si, logic sw);
        in_w = iw;
        w_w  = ww;
        s_i  = si;
        s_w  = sw;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] widths [5];
        widths = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3};

        // 1. Reset with nonzero inputs
        rst_n = 1'b0;
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
        wts = '1;
        ins = '1;
        #3;
        for (int c = 0; c < N; c++) check_const("reset_async", c, 32'd0);
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) check_const("reset_held", c, 32'd0);

        // 2. Identity, unsigned 8-bit
        ins = '0;
        wts = '0;
        for (int r = 0; r < N; r++) begin
            wts[(r*N+r)*8 +: 8] = 8'd1;
            ins[r*8 +: 8] = 8'(r + 1);
        end
        do_reset("ident_rst");
        for (int k = 0; k < N + 2; k++) tick("ident");
        for (int c = 0; c < N; c++) check_const("ident_val", c, 32'(c + 1));

        // 3. Signed / unsigned 8-bit with 0xFF weights
        wts = '1;
        ins = {N{8'h02}};
        set_cfg(4'd8, 4'd8, 1'b1, 1'b1);
        do_reset("s8_rst");
        for (int k = 0; k < N; k++) tick("s8");
        for (int c = 0; c < N; c++) check_const("s8_val", c, 32'hFFFF_FFF0);
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
        do_reset("u8_rst");
        for (int k = 0; k < N; k++) tick("u8");
        for (int c = 0; c < N; c++) check_const("u8_val", c, 32'h0000_0FF0);

        // 4. Width 4 operands
        wts = {N*N{8'h25}};
        ins = {N{8'hF3}};
        set_cfg(4'd4, 4'd4, 1'b0, 1'b0);
        do_reset("w4_rst");
        for (int k = 0; k < N; k++) tick("w4u");
        for (int c = 0; c < N; c++) check_const("w4u_val", c, 32'd120);
        ins = {N{8'hFB}};
        set_cfg(4'd4, 4'd4, 1'b1, 1'b0);
        do_reset("w4s_rst");
        for (int k = 0; k < N; k++) tick("w4s");
        for (int c = 0; c < N; c++) check_const("w4s_val", c, -32'sd200);

        // 5. Latency step and back-to-back vectors
        wts = {N*N{8'h01}};
        ins = '0;
        set_cfg(4'd8, 4'd8, 1'b0, 1'b0);
        do_reset("lat_rst");
        for (int k = 0; k < N + 2; k++) tick("lat_zero");
        ins = {N{8'h01}};
        for (int k = 0; k < N - 1; k++) begin
            tick("lat_step");
            check_const("lat_before", 0, 32'd0);
        end
        tick("lat_step");
        check_const("lat_arrive", 0, 32'd8);
        for (int k = 0; k < 12; k++) begin
            ins = {$urandom, $urandom};
            tick("b2b");
        end

        // 6. Mid-operation reset while streaming
        for (int k = 0; k < 4; k++) begin
            ins = {$urandom, $urandom};
            tick("mid_pre");
        end
        ins = {N{8'h03}};
        do_reset("mid_rst");
        for (int k = 0; k < N - 1; k++) begin
            tick("mid_fill");
            check_const("mid_zero", N - 1, 32'd0);
        end
        tick("mid_first");
        check_const("mid_first_val", N - 1, 32'd24);

        // Randomized configurations, including an out-of-range width
        for (int t = 0; t < 12; t++) begin
            set_cfg(widths[$urandom_range(0, 4)], widths[$urandom_range(0, 4)],
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < N*N*8; i += 32) wts[i +: 32] = $urandom;
            do_reset("rnd_rst");
            for (int k = 0; k < 20; k++) begin
                ins = {$urandom, $urandom};
                tick("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Weight-stationary ARRAY_SIZE×ARRAY_SIZE multiply-accumulate array with run-time selectable operand precision (1/2/4/8 bit) and signedness, in the style of Bit-Fusion. Each cycle it accepts one input vector and produces one output row, psums[c] = Σ_r inputs[r]·weights[r·ARRAY_SIZE+c]. It is the compute core between the input/weight buffers and the output accumulators.

## Interface
- ARRAY_SIZE, 8, number of rows (input lanes) and columns (output lanes).
- clk  in  1  single clock; all registers rise-edge triggered.
- rst_n  in  1  asynchronous, active-low reset.
- in_width  in  4  input operand width in bits: 1, 2, 4 or 8; any other value is treated as 8.
- weight_width  in  4  weight operand width, same encoding as in_width.
- s_in  in  1  1 = inputs are two's-complement, 0 = unsigned.
- s_weight  in  1  1 = weights are two's-complement, 0 = unsigned.
- weights  in  ARRAY_SIZE·ARRAY_SIZE×8 (packed)  element r·ARRAY_SIZE+c is the weight at row r, column c.
- inputs  in  ARRAY_SIZE×8 (packed)  element r feeds row r.
- psums  out  ARRAY_SIZE×32 (packed)  element c is the dot product for column c.

## Operation
- Operand decode, per 8-bit lane: take the low W bits (W from the width port); sign-extend from bit W-1 if the sign flag is set, otherwise zero-extend. Signed 1-bit gives {0, -1}.
- PE(r,c): psum_out = psum_in + x_r·w_rc.
  - Product is a 16-bit signed value, sign-extended to 32 bits.
  - Accumulation is 32-bit modulo 2^32; wrap is silent.
  - Row 0 uses psum_in = 0.
- Inputs are broadcast along a row. Row r receives inputs[r] through a skew chain of r registers. Each PE registers its psum_out, so partial sums flow down the columns.
- psums[c] is the registered psum_out of PE(ARRAY_SIZE-1, c). All columns are aligned, so no output deskew is needed.
- weights, in_width, weight_width, s_in and s_weight are used combinationally by every PE and are not registered.
  - They must be held stable for a whole computation.
  - Changing them while data is in flight produces a mixed result, with no error flag.
- There is no valid/ready handshake. The array computes every cycle, and the consumer tracks latency.

## Timing
- Reset: all skew registers and PE psum registers clear to 0 asynchronously. psums = 0 while rst_n is low.
- Latency is ARRAY_SIZE edges. An input vector held across edge k appears on psums immediately after edge k+ARRAY_SIZE-1.
- Throughput is one vector per cycle.
- After edge j, psums is a consistent dot product of the vector sampled at edge j-ARRAY_SIZE+1. No partial mixes arise from input changes alone.
- After reset release:
  - Partially filled pipeline stages contribute 0.
  - The first full result follows the rule above, counting from the first edge with rst_n high.
- Reset asserted mid-operation discards all in-flight data immediately.

## Structure
- Package systolic_pkg:
  - DATA_W = 8, ACC_W = 32, PROD_W = 16.
  - Function decode_operand(value, width, signed) returning a 9-bit signed value.
- Sub-module systolic_pe contains the multiplier, adder and psum register; its weight, input, width and sign inputs are combinational.
- Top level contains generate loops for the skew chains, the PE grid and the output mapping.

## Test plan
All cases use ARRAY_SIZE = 8.
1. Reset: drive rst_n low with nonzero inputs -> psums = 0 on every lane, asynchronously.
2. Identity, unsigned 8-bit: weights[r·8+c] = (r==c), inputs = 1..8 -> psums[c] = c+1 from edge 8 after release onward.
3. Signed 8-bit: all weights 0xFF, all inputs 0x02.
   - s_in = s_weight = 1 -> every psum = 0xFFFFFFF0 (-16).
   - s_in = s_weight = 0 -> every psum = 0x00000FF0.
4. Width 4, unsigned: inputs 0xF3, weights 0x25 -> operands 3 and 5, every psum = 120. With s_in = 1 and inputs 0xFB -> (-5·5)·8 = -200.
5. Latency: step inputs from all-0 to all-1 (weights 1) at edge k -> psums = 0 through edge k+6 and 8 after edge k+7. Back-to-back vectors emerge one per cycle.
6. Mid-operation reset: pulse rst_n low for 1 cycle while streaming -> psums drop to 0 at once; the first nonzero result appears 8 edges after release.
